k16_bus_fabric: RTL and testbench
=================================

Name: k16_bus_fabric

Overview:
Parametrised, registered memory-map fabric for the K16 system. It replaces the fixed combinational address decode with N configurable regions, per-region wait states, a req/ready handshake toward the CPU, a video hold stall, and sticky bus-error capture for unmapped accesses. It sits between K16Cpu and the RAM/frame-buffer/ROM/IO slaves. All slaves are synchronous with one-cycle read latency.

Parameters:
NUM_REGIONS, 4, number of decoded slave regions (1..8)
ADDR_W, 16, address width
DATA_W, 16, data width
WAIT_W, 2, width of per-region wait-state field
REGION_BASE, {16'hFFF8,16'hF000,16'h8000,16'h0000}, packed NUM_REGIONS*ADDR_W; region i base (index 0 = LSBs)
REGION_MASK, {16'hFFF8,16'hFE00,16'hF800,16'hF000}, packed; region i hit when (addr & mask) == base
REGION_WAIT, {2'd2,2'd1,2'd0,2'd0}, packed NUM_REGIONS*WAIT_W; extra wait cycles per region
UNMAPPED_DATA, 16'h9FFF, read data returned for unmapped addresses

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous reset, active low
hold  input  1  video stall; while high no new access is accepted
m_req  input  1  master request, held until m_ready
m_write  input  1  1 = write, 0 = read
m_addr  input  ADDR_W  master address
m_wdata  input  DATA_W  master write data
m_rdata  output  DATA_W  read data, valid with m_ready, held until next completion
m_ready  output  1  one-cycle completion pulse
m_error  output  1  high with m_ready when access was unmapped
s_sel  output  NUM_REGIONS  one-hot slave strobe
s_write  output  1  write qualifier for s_sel
s_addr  output  ADDR_W  latched address (slaves slice low bits)
s_wdata  output  DATA_W  latched write data
s_rdata  input  NUM_REGIONS*DATA_W  packed slave read data
err_valid  output  1  sticky unmapped-access flag
err_addr  output  ADDR_W  address of first unmapped access since clear
err_clear  input  1  clears err_valid

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0, including m_rdata, err_addr and s_addr.
- Decode: region i hits when (m_addr & MASK[i]) == BASE[i]. Overlaps resolve to the lowest index.
- FSM states IDLE, STROBE, WAIT, CAPTURE, DONE.
- IDLE: on an edge with m_req=1 and hold=0, latch addr, write and wdata into s_addr/s_wdata, latch region and wait count.
  - Hit: go to STROBE.
  - Miss: go to DONE with m_error=1.
- STROBE: s_sel[i]=1 and s_write=latched write for exactly this cycle. Next state is WAIT if wait>0, else CAPTURE.
- WAIT: down-counter from REGION_WAIT[i]; exits to CAPTURE when the count reaches 1. s_sel stays 0.
- CAPTURE: register s_rdata[i] into m_rdata (reads only; writes leave m_rdata unchanged). Next state DONE.
- DONE: m_ready=1 for one cycle. m_error=1 only on a miss; a read miss drives m_rdata=UNMAPPED_DATA. Next state IDLE.
- Latency from the accepting edge to the m_ready cycle: mapped = 3+W cycles; unmapped = 1 cycle.
- Master drops m_req, or presents the next access, in the cycle after m_ready. A request still high in IDLE is accepted again (back-to-back).
- hold is ignored once an access is accepted; it only blocks acceptance.
- Unmapped write: no slave is strobed and the data is discarded.
- Error capture: on a miss, if err_valid=0, set err_valid and load err_addr. A later miss does not overwrite err_addr.
- err_clear together with a new miss in the same cycle: the set wins and err_addr takes the new address.

Decomposition:
- Package k16_bus_pkg: FSM state enum, default region constants (RAM/FB/ROM/IO base, mask, wait), UNMAPPED_DATA default.
- Sub-module k16_region_decode: combinational priority matcher producing hit, index and one-hot outputs.
- FSM, wait counter and error capture live in k16_bus_fabric.

Test Plan:
1. Read 16'h0123, RAM slave returns 16'hBEEF → s_sel=4'b0001 one cycle after accept; m_ready at +3; m_rdata=16'hBEEF; m_error=0.
2. Write 16'h8005 data 16'h1234 → s_sel=4'b0010 and s_write=1 for one cycle; s_wdata=16'h1234; m_ready at +3.
3. Read ROM 16'hF010 (W=1) → m_ready at +4. Read IO 16'hFFFA (W=2) → m_ready at +5.
4. Read 16'h4000 → m_ready at +1; m_error=1; m_rdata=16'h9FFF; err_valid=1; err_addr=16'h4000. Then miss 16'h5000 → err_addr stays 16'h4000. Pulse err_clear together with miss 16'h6000 → err_valid=1, err_addr=16'h6000.
5. hold=1 for 5 cycles with m_req=1 → no s_sel. Release hold → accept on the next edge. Raise hold mid-WAIT → completion timing unchanged.
6. Drop reset_n during WAIT → outputs 0 immediately and state IDLE. After release, a new read completes normally.

Source files
------------

// File: rtl/k16_bus_pkg.sv
// k16_bus_pkg: shared FSM state type and default K16 memory map
package k16_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STROBE,
        ST_WAIT,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    localparam logic [15:0] RAM_BASE = 16'h0000;
    localparam logic [15:0] RAM_MASK = 16'hF000;
    localparam logic [1:0]  RAM_WAIT = 2'd0;
    localparam logic [15:0] FB_BASE  = 16'h8000;
    localparam logic [15:0] FB_MASK  = 16'hF800;
    localparam logic [1:0]  FB_WAIT  = 2'd0;
    localparam logic [15:0] ROM_BASE = 16'hF000;
    localparam logic [15:0] ROM_MASK = 16'hFE00;
    localparam logic [1:0]  ROM_WAIT = 2'd1;
    localparam logic [15:0] IO_BASE  = 16'hFFF8;
    localparam logic [15:0] IO_MASK  = 16'hFFF8;
    localparam logic [1:0]  IO_WAIT  = 2'd2;

    localparam logic [63:0] DEF_REGION_BASE   = {IO_BASE, ROM_BASE, FB_BASE, RAM_BASE};
    localparam logic [63:0] DEF_REGION_MASK   = {IO_MASK, ROM_MASK, FB_MASK, RAM_MASK};
    localparam logic [7:0]  DEF_REGION_WAIT   = {IO_WAIT, ROM_WAIT, FB_WAIT, RAM_WAIT};
    localparam logic [15:0] DEF_UNMAPPED_DATA = 16'h9FFF;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/k16_region_decode.sv
// k16_region_decode: priority address matcher over the configured regions
module k16_region_decode #(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W = 16,
    parameter int IDX_W = 2,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = '0
) (
    input  logic [ADDR_W-1:0]      addr,
    output logic                   hit,
    output logic [IDX_W-1:0]       idx,
    output logic [NUM_REGIONS-1:0] onehot
);

    // scan from the top so the lowest matching index is the one left standing
    always_comb begin
        hit = 1'b0;
        idx = '0;
        onehot = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
                onehot = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/k16_bus_fabric.sv
// k16_bus_fabric: registered region decode, wait states and bus-error capture for the K16 bus
module k16_bus_fabric
    import k16_bus_pkg::*;
#(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WAIT_W = 2,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = DEF_REGION_MASK,
    parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAIT = DEF_REGION_WAIT,
    parameter logic [DATA_W-1:0] UNMAPPED_DATA = DEF_UNMAPPED_DATA
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          hold,
    input  logic                          m_req,
    input  logic                          m_write,
    input  logic [ADDR_W-1:0]             m_addr,
    input  logic [DATA_W-1:0]             m_wdata,
    output logic [DATA_W-1:0]             m_rdata,
    output logic                          m_ready,
    output logic                          m_error,
    output logic [NUM_REGIONS-1:0]        s_sel,
    output logic                          s_write,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    input  logic [NUM_REGIONS*DATA_W-1:0] s_rdata,
    output logic                          err_valid,
    output logic [ADDR_W-1:0]             err_addr,
    input  logic                          err_clear
);

    localparam int IDX_W = idx_width(NUM_REGIONS);

    state_t                 state, state_nx;
    logic                   hit, accept, write_q, miss_q;
    logic [IDX_W-1:0]       idx, idx_q;
    logic [NUM_REGIONS-1:0] onehot, sel_q;
    logic [WAIT_W-1:0]      cnt;

    k16_region_decode #(
        .NUM_REGIONS(NUM_REGIONS),
        .ADDR_W(ADDR_W),
        .IDX_W(IDX_W),
        .REGION_BASE(REGION_BASE),
        .REGION_MASK(REGION_MASK)
    ) u_decode (
        .addr(m_addr),
        .hit(hit),
        .idx(idx),
        .onehot(onehot)
    );

    assign accept  = (state == ST_IDLE) && m_req && !hold;
    assign m_ready = (state == ST_DONE);
    assign m_error = m_ready && miss_q;
    assign s_sel   = (state == ST_STROBE) ? sel_q : '0;
    assign s_write = (state == ST_STROBE) && write_q;

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    // next-state: misses skip straight to completion, hits walk strobe/wait/capture
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    state_nx = accept ? (hit ? ST_STROBE : ST_DONE) : ST_IDLE;
            ST_STROBE:  state_nx = (cnt != '0) ? ST_WAIT : ST_CAPTURE;
            ST_WAIT:    state_nx = (cnt == WAIT_W'(1)) ? ST_CAPTURE : ST_WAIT;
            ST_CAPTURE: state_nx = ST_DONE;
            ST_DONE:    state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // request latch, wait countdown, read data capture and sticky error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_addr    <= '0;
            s_wdata   <= '0;
            write_q   <= 1'b0;
            miss_q    <= 1'b0;
            idx_q     <= '0;
            sel_q     <= '0;
            cnt       <= '0;
            m_rdata   <= '0;
            err_valid <= 1'b0;
            err_addr  <= '0;
        end else begin
            if (accept) begin
                s_addr  <= m_addr;
                s_wdata <= m_wdata;
                write_q <= m_write;
                miss_q  <= !hit;
                idx_q   <= idx;
                sel_q   <= onehot;
                cnt     <= REGION_WAIT[idx*WAIT_W +: WAIT_W];
                if (!hit && !m_write) m_rdata <= UNMAPPED_DATA;
            end
            if (state == ST_WAIT) cnt <= cnt - 1'b1;
            if (state == ST_CAPTURE && !write_q) m_rdata <= s_rdata[idx_q*DATA_W +: DATA_W];
            if (accept && !hit && (!err_valid || err_clear)) begin
                err_valid <= 1'b1;
                err_addr  <= m_addr;
            end else if (err_clear) begin
                err_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_k16_bus_fabric.sv
// tb_k16_bus_fabric: directed vector bench for the K16 bus fabric
module tb_k16_bus_fabric;

    logic        clk, reset_n, hold, m_req, m_write, err_clear;
    logic [15:0] m_addr, m_wdata, m_rdata, s_addr, s_wdata, err_addr;
    logic        m_ready, m_error, s_write, err_valid;
    logic [3:0]  s_sel;
    logic [63:0] s_rdata;

    k16_bus_fabric dut (
        .clk(clk),
        .reset_n(reset_n),
        .hold(hold),
        .m_req(m_req),
        .m_write(m_write),
        .m_addr(m_addr),
        .m_wdata(m_wdata),
        .m_rdata(m_rdata),
        .m_ready(m_ready),
        .m_error(m_error),
        .s_sel(s_sel),
        .s_write(s_write),
        .s_addr(s_addr),
        .s_wdata(s_wdata),
        .s_rdata(s_rdata),
        .err_valid(err_valid),
        .err_addr(err_addr),
        .err_clear(err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        hold_mid;
        int          lat;
        logic [3:0]  sel;
        logic [15:0] rdata;
        logic        err;
        logic        ev;
        logic [15:0] ea;
    } vec_t;

    vec_t vt[12];
    int   n_vec, n_fail;
    int   o_lat, o_nstb, o_stb_at;
    logic [3:0]  o_sel;
    logic        o_swr;
    logic [15:0] o_swd;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present a request, let the first edge accept it, run until m_ready or budget expires
    task automatic run_access(input logic wr, input logic [15:0] a, input logic [15:0] d, input logic hm);
        m_req = 1'b1;
        m_write = wr;
        m_addr = a;
        m_wdata = d;
        step();
        hold = hm;
        o_lat = 1;
        o_nstb = 0;
        o_stb_at = 0;
        o_sel = '0;
        o_swr = 1'b0;
        o_swd = '0;
        while (!m_ready && o_lat < 20) begin
            if (s_sel != '0) begin
                o_nstb++;
                o_sel |= s_sel;
                o_stb_at = o_lat;
                o_swr = s_write;
                o_swd = s_wdata;
            end
            step();
            o_lat++;
        end
    endtask

    task automatic finish_access();
        m_req = 1'b0;
        hold = 1'b0;
        step();
    endtask

    initial begin
        int lat;
        logic [3:0] sel_or;
        logic rdy_or;
        n_vec = 0;
        n_fail = 0;
        vt[0]  = '{1'b0, 16'h0123, 16'h0000, 1'b0, 3, 4'b0001, 16'hBEEF, 1'b0, 1'b0, 16'h0000};
        vt[1]  = '{1'b1, 16'h8005, 16'h1234, 1'b0, 3, 4'b0010, 16'hBEEF, 1'b0, 1'b0, 16'h0000};
        vt[2]  = '{1'b0, 16'hF010, 16'h0000, 1'b0, 4, 4'b0100, 16'hC0DE, 1'b0, 1'b0, 16'h0000};
        vt[3]  = '{1'b0, 16'hFFFA, 16'h0000, 1'b1, 5, 4'b1000, 16'h1DEA, 1'b0, 1'b0, 16'h0000};
        vt[4]  = '{1'b0, 16'h87FF, 16'h0000, 1'b0, 3, 4'b0010, 16'hF00D, 1'b0, 1'b0, 16'h0000};
        vt[5]  = '{1'b1, 16'h0FFE, 16'h5A5A, 1'b0, 3, 4'b0001, 16'hF00D, 1'b0, 1'b0, 16'h0000};
        vt[6]  = '{1'b0, 16'h4000, 16'h0000, 1'b0, 1, 4'b0000, 16'h9FFF, 1'b1, 1'b1, 16'h4000};
        vt[7]  = '{1'b1, 16'hF1FF, 16'hA5A5, 1'b0, 4, 4'b0100, 16'h9FFF, 1'b0, 1'b1, 16'h4000};
        vt[8]  = '{1'b1, 16'h5000, 16'h7777, 1'b0, 1, 4'b0000, 16'h9FFF, 1'b1, 1'b1, 16'h4000};
        vt[9]  = '{1'b0, 16'hFFF8, 16'h0000, 1'b0, 5, 4'b1000, 16'h1DEA, 1'b0, 1'b1, 16'h4000};
        vt[10] = '{1'b0, 16'hFE00, 16'h0000, 1'b0, 1, 4'b0000, 16'h9FFF, 1'b1, 1'b1, 16'h4000};
        vt[11] = '{1'b0, 16'h8100, 16'h0000, 1'b0, 3, 4'b0010, 16'hF00D, 1'b0, 1'b1, 16'h4000};

        reset_n = 1'b0;
        hold = 1'b0;
        m_req = 1'b0;
        m_write = 1'b0;
        m_addr = '0;
        m_wdata = '0;
        err_clear = 1'b0;
        s_rdata = {16'h1DEA, 16'hC0DE, 16'hF00D, 16'hBEEF};
        #1;
        check("rst_m_rdata", 32'(m_rdata), 32'h0);
        check("rst_ctrl", 32'({m_ready, m_error, s_write, err_valid, s_sel}), 32'h0);
        check("rst_s_addr", 32'(s_addr), 32'h0);
        check("rst_err_addr", 32'(err_addr), 32'h0);
        step();
        step();
        @(negedge clk);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 12; i++) begin
            run_access(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].hold_mid);
            check($sformatf("v%0d_latency", i), 32'(o_lat), 32'(vt[i].lat));
            check($sformatf("v%0d_sel", i), 32'(o_sel), 32'(vt[i].sel));
            check($sformatf("v%0d_strobes", i), 32'(o_nstb), (vt[i].sel != '0) ? 32'd1 : 32'd0);
            if (vt[i].sel != '0) begin
                check($sformatf("v%0d_strobe_cycle", i), 32'(o_stb_at), 32'd1);
                check($sformatf("v%0d_s_write", i), 32'(o_swr), 32'(vt[i].wr));
            end
            if (vt[i].wr && vt[i].sel != '0) check($sformatf("v%0d_s_wdata", i), 32'(o_swd), 32'(vt[i].wdata));
            check($sformatf("v%0d_s_addr", i), 32'(s_addr), 32'(vt[i].addr));
            check($sformatf("v%0d_m_rdata", i), 32'(m_rdata), 32'(vt[i].rdata));
            check($sformatf("v%0d_m_error", i), 32'(m_error), 32'(vt[i].err));
            check($sformatf("v%0d_err_valid", i), 32'(err_valid), 32'(vt[i].ev));
            check($sformatf("v%0d_err_addr", i), 32'(err_addr), 32'(vt[i].ea));
            finish_access();
            check($sformatf("v%0d_ready_pulse", i), 32'(m_ready), 32'h0);
        end

        m_req = 1'b1;
        m_write = 1'b0;
        m_addr = 16'h6000;
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("clr_miss_ready", 32'({m_ready, m_error}), 32'h3);
        check("clr_miss_valid", 32'(err_valid), 32'h1);
        check("clr_miss_addr", 32'(err_addr), 32'h6000);
        finish_access();
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("clr_only_valid", 32'(err_valid), 32'h0);
        run_access(1'b0, 16'h7000, 16'h0000, 1'b0);
        check("miss_after_clr_lat", 32'(o_lat), 32'd1);
        check("miss_after_clr_valid", 32'(err_valid), 32'h1);
        check("miss_after_clr_addr", 32'(err_addr), 32'h7000);
        finish_access();

        hold = 1'b1;
        m_req = 1'b1;
        m_write = 1'b0;
        m_addr = 16'h0123;
        sel_or = '0;
        rdy_or = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            sel_or |= s_sel;
            rdy_or |= m_ready;
        end
        check("hold_no_sel", 32'(sel_or), 32'h0);
        check("hold_no_ready", 32'(rdy_or), 32'h0);
        hold = 1'b0;
        step();
        check("hold_release_sel", 32'(s_sel), 32'h1);
        lat = 1;
        while (!m_ready && lat < 20) begin
            step();
            lat++;
        end
        check("hold_release_lat", 32'(lat), 32'd3);
        check("hold_release_rdata", 32'(m_rdata), 32'hBEEF);
        finish_access();

        m_req = 1'b1;
        m_write = 1'b0;
        m_addr = 16'hFFFA;
        step();
        step();
        check("pre_reset_in_wait", 32'({s_sel, m_ready}), 32'h0);
        reset_n = 1'b0;
        #1;
        check("async_rst_rdata", 32'(m_rdata), 32'h0);
        check("async_rst_ctrl", 32'({m_ready, m_error, s_write, err_valid, s_sel}), 32'h0);
        check("async_rst_addrs", 32'({s_addr, err_addr}), 32'h0);
        m_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("post_reset_idle", 32'(m_ready), 32'h0);
        run_access(1'b0, 16'h0123, 16'h0000, 1'b0);
        check("post_reset_lat", 32'(o_lat), 32'd3);
        check("post_reset_sel", 32'(o_sel), 32'h1);
        check("post_reset_rdata", 32'(m_rdata), 32'hBEEF);
        finish_access();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
